// File: rtl/rw_bus_master_pkg.sv
// Shared constants and state encoding for the rw_bus_master data-memory initiator.
package rw_bus_master_pkg;

  localparam logic [7:0]  BASE_ADDR = 8'd128;
  localparam logic [7:0]  TOP_ADDR  = 8'd223;
  localparam int unsigned LEN_W     = 3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  function automatic logic in_window(input logic [7:0] addr);
    return (addr >= BASE_ADDR) && (addr <= TOP_ADDR);
  endfunction

endpackage

// File: rtl/rw_bus_master_if.sv
// Request, write-beat, read-beat and memory pins of the rw_bus_master.
// Handshakes: a request or write beat transfers on a rising edge where its
// valid and ready are both high; read beats have no ready and must be taken
// in the cycle rd_valid is high.
interface rw_bus_master_if;
  import rw_bus_master_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [7:0]           req_addr;
  logic [LEN_W-1:0]     req_len;
  logic [7:0]           wr_data;
  logic                 wr_valid;
  logic                 wr_ready;
  logic [7:0]           rd_data;
  logic                 rd_valid;
  logic                 rd_last;
  logic                 done;
  logic                 err;
  logic [7:0]           address;
  logic                 WE;
  logic [7:0]           data_in;
  logic [7:0]           data_out;

  modport master (
    input  req_valid, req_write, req_addr, req_len, wr_data, wr_valid, data_out,
    output req_ready, wr_ready, rd_data, rd_valid, rd_last, done, err,
           address, WE, data_in
  );

  modport slave (
    output req_valid, req_write, req_addr, req_len, wr_data, wr_valid, data_out,
    input  req_ready, wr_ready, rd_data, rd_valid, rd_last, done, err,
           address, WE, data_in
  );

endinterface

// File: rtl/rw_rd_pipe.sv
// Two-stage read pipe: stage 1 covers the memory's registered output, stage 2
// captures data_out so rd_data/rd_valid/rd_last leave the master registered.
module rw_rd_pipe (
  input  logic       clk,
  input  logic       reset,
  input  logic       issue,
  input  logic       issue_last,
  input  logic [7:0] data_out,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       rd_last,
  output logic       empty_next
);

  logic s1_valid;
  logic s1_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      rd_data  <= 8'h00;
    end else begin
      s1_valid <= issue;
      s1_last  <= issue & issue_last;
      rd_valid <= s1_valid;
      rd_last  <= s1_last;
      if (s1_valid) rd_data <= data_out;
    end
  end

  // Output stage holds the youngest beat: the pipe is empty after this cycle.
  assign empty_next = rd_valid & ~s1_valid;

endmodule

// File: rtl/rw_bus_master.sv
// Single/burst read-write initiator for the 96x8 data memory at 128..223.
module rw_bus_master
  import rw_bus_master_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  rw_bus_master_if.master bus,
  output state_t          fsm_state
);

  state_t           state, state_n;
  logic [7:0]       cur_addr, cur_addr_n;
  logic [LEN_W-1:0] remaining, remaining_n;
  logic             truncated, truncated_n;
  logic             done_n;
  logic             we_raw;
  logic             issue;
  logic             issue_last;
  logic             empty_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cur_addr  <= 8'h00;
      remaining <= '0;
      truncated <= 1'b0;
      bus.done  <= 1'b0;
      bus.err   <= 1'b0;
    end else begin
      state     <= state_n;
      cur_addr  <= cur_addr_n;
      remaining <= remaining_n;
      truncated <= truncated_n;
      bus.done  <= done_n;
      bus.err   <= (state == S_ERR);
    end
  end

  always_comb begin
    state_n       = state;
    cur_addr_n    = cur_addr;
    remaining_n   = remaining;
    truncated_n   = truncated;
    done_n        = 1'b0;
    bus.req_ready = 1'b0;
    bus.wr_ready  = 1'b0;
    bus.address   = 8'h00;
    bus.data_in   = 8'h00;
    we_raw        = 1'b0;
    issue         = 1'b0;
    issue_last    = 1'b0;
    case (state)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          cur_addr_n  = bus.req_addr;
          remaining_n = bus.req_len;
          truncated_n = 1'b0;
          if (!in_window(bus.req_addr)) state_n = S_ERR;
          else if (bus.req_write)       state_n = S_WRITE;
          else                          state_n = S_READ;
        end
      end
      S_WRITE: begin
        bus.address  = cur_addr;
        bus.data_in  = bus.wr_data;
        bus.wr_ready = 1'b1;
        we_raw       = bus.wr_valid;
        if (bus.wr_valid) begin
          if (remaining == '0) begin
            state_n = S_IDLE;
            done_n  = 1'b1;
          end else if (cur_addr == TOP_ADDR) begin
            state_n = S_ERR;
          end else begin
            cur_addr_n  = cur_addr + 8'd1;
            remaining_n = remaining - 1'b1;
          end
        end
      end
      S_READ: begin
        bus.address = cur_addr;
        issue       = 1'b1;
        if (remaining == '0) begin
          issue_last = 1'b1;
          state_n    = S_DRAIN;
        end else if (cur_addr == TOP_ADDR) begin
          truncated_n = 1'b1;
          state_n     = S_DRAIN;
        end else begin
          cur_addr_n  = cur_addr + 8'd1;
          remaining_n = remaining - 1'b1;
        end
      end
      S_DRAIN: begin
        if (empty_next) begin
          if (truncated) begin
            state_n = S_ERR;
          end else begin
            state_n = S_IDLE;
            done_n  = 1'b1;
          end
        end
      end
      S_ERR:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Gated combinationally so a write can never land on a reset edge.
  assign bus.WE    = we_raw & ~reset;
  assign fsm_state = state;

  rw_rd_pipe u_rd_pipe (
    .clk        (clk),
    .reset      (reset),
    .issue      (issue),
    .issue_last (issue_last),
    .data_out   (bus.data_out),
    .rd_data    (bus.rd_data),
    .rd_valid   (bus.rd_valid),
    .rd_last    (bus.rd_last),
    .empty_next (empty_next)
  );

endmodule

// File: doc/rw_bus_master.md
Name: rw_bus_master

Overview:
- Bus initiator for the 96x8 synchronous read/write data memory mapped at addresses 128–223.
- Accepts single or burst read/write requests from the control path over a valid/ready handshake.
- Drives the memory's address, WE and data_in pins, and captures its registered data_out.
- Rejects out-of-window accesses with an error pulse, without touching the memory.

Parameters:
BASE_ADDR, 128, lowest legal memory address
TOP_ADDR, 223, highest legal memory address
LEN_W, 3, width of req_len; burst length = req_len+1 beats (1..8)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  master can accept request (high only in IDLE)
req_write  input  1  1 = write burst, 0 = read burst
req_addr  input  8  start address
req_len  input  LEN_W  beats minus one
wr_data  input  8  write beat data
wr_valid  input  1  write beat present
wr_ready  output  1  write beat accepted this cycle when wr_valid also high
rd_data  output  8  registered read beat data
rd_valid  output  1  rd_data valid this cycle (no backpressure)
rd_last  output  1  final beat of a complete read burst
done  output  1  one-cycle pulse: burst completed without error
err  output  1  one-cycle pulse: burst rejected or truncated
address  output  8  to memory address
WE  output  1  to memory WE
data_in  output  8  to memory data_in
data_out  input  8  from memory data_out

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; beat counter and address register cleared.
  - Read pipe emptied.
  - Outputs: rd_data=0, rd_valid=0, rd_last=0, done=0, err=0, address=0, data_in=0.
  - WE is gated by !reset combinationally, so no write can occur on the reset edge.
- States: IDLE, WRITE, READ, DRAIN, ERR.
- IDLE:
  - req_ready=1; address=0 (outside window, memory disabled); WE=0.
  - On req_valid: latch req_write, req_addr into cur_addr, req_len into remaining.
  - If req_addr<BASE_ADDR or >TOP_ADDR → ERR; else if req_write → WRITE; else → READ.
- WRITE:
  - address=cur_addr; data_in=wr_data; wr_ready=1; WE=wr_valid (combinational).
  - Memory writes on the same edge the beat is accepted.
  - If wr_valid=0, the cycle is a stall: address holds, WE=0.
  - On an accepted beat:
    - If remaining==0: → IDLE, with done=1 the following cycle.
    - Else if cur_addr==TOP_ADDR: → ERR. The burst is truncated and later beats are never accepted; the requester discards them.
    - Else: cur_addr+1, remaining-1.
- READ:
  - address=cur_addr; WE=0; one beat issued per cycle, no stalls.
  - Memory registers data_out at the issue edge.
  - The master captures data_out one cycle later into rd_data, registered.
  - rd_valid for a beat issued in cycle n is therefore high in cycle n+2.
  - Beat 0 is issued in the cycle after acceptance, so rd_valid for beat 0 is 3 cycles after the accept cycle. Subsequent beats follow back-to-back.
  - After issuing the last beat, or issuing TOP_ADDR with beats remaining (sets a truncated flag), → DRAIN; address=0.
- DRAIN:
  - Waits until the 2-stage read pipe is empty.
  - rd_last is asserted with the final beat only if the burst was not truncated.
  - On the final beat's rd_valid cycle: → IDLE with done=1 the next cycle, or → ERR if truncated.
- ERR: err=1 for exactly one cycle; → IDLE. No WE is asserted in ERR.
- Width rules:
  - cur_addr is 8-bit and never wraps, since the TOP_ADDR check precedes any increment.
  - remaining is LEN_W bits.
- Simultaneous events: a new req_valid during a non-IDLE state is ignored (req_ready=0).
- done and err are never high together.

Decomposition:
- Shared package:
  - BASE_ADDR/TOP_ADDR constants shared with the memory and I/O port blocks.
  - State encoding localparams: IDLE, WRITE, READ, DRAIN, ERR.
- Natural sub-module: rw_rd_pipe, a 2-stage valid/last/tag shift pipe. It aligns the registered memory data with rd_valid and rd_last, and reports empty to the FSM.

Test Plan:
- Single write 0x80←0xA5, then single read 0x80:
  - WE high exactly one cycle with address=0x80.
  - Read gives rd_valid 3 cycles after accept, rd_data=0xA5, rd_last=1, then done pulse.
- Write burst 0x90, len=3, data 11,22,33,44, then read burst 0x90 len=3:
  - Four consecutive rd_valid cycles with 0x11, 0x22, 0x33, 0x44.
  - rd_last only on 0x44; one done pulse.
- Request address 0x7F, and separately 0xE0:
  - err pulse 2 cycles after accept; WE never high; address stays 0; done=0.
- Write burst 0xDE, len=3:
  - Beats land at 0xDE and 0xDF, then wr_ready drops and err pulses.
  - Readback of 0xDE/0xDF matches; a read burst 0xDE len=3 gives 2 beats, no rd_last, then err.
- Write burst with wr_valid low 2 cycles between beats:
  - WE low and address held during the gap.
  - Data lands at consecutive addresses; done after the last beat.
- Reset asserted during a read burst beat 1:
  - Next cycle: state IDLE, req_ready=1, rd_valid=0, address=0.
  - No stale rd_valid appears afterwards.
